// File: rtl/mux4_arbiter_if.sv
// Bus bundle between four valid/ready requesters, the mux4_arbiter and its single downstream consumer.
// The "slave" modport is the arbiter's view and the "master" modport is the requester/consumer side.
interface mux4_arbiter_if #(
    parameter int WIDTH = 64
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data_in;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               busy;

    modport master (
        output req, data_in, out_ready,
        input  gnt, sel, out_valid, out_data, busy
    );

    modport slave (
        input  req, data_in, out_ready,
        output gnt, sel, out_valid, out_data, busy
    );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 datapath mux, with bounded bursts and back-to-back handover.
// Optional per-requester saturating transfer counters are enabled by defining MUXARB_PERF_CNT_EN.
module mux4_arbiter #(
    parameter int WIDTH = 64,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mux4_arbiter_if.slave bus
`ifdef MUXARB_PERF_CNT_EN
    ,
    input  logic [1:0]    cnt_sel,
    output logic [15:0]   cnt_out
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    state_t     state, state_n;
    logic [1:0] owner, owner_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] beat_cnt, beat_n;
    logic [3:0] gnt, gnt_n;

    logic       busy;
    logic       transfer;
    logic       dropped;
    logic       last_beat;
    logic [3:0] arb_req;
    logic [1:0] arb_start;
    pick_t      pick;

    // First set bit of r scanning start, start+1, ... modulo 4.
    function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] start);
        pick_t      p;
        logic [1:0] k;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            k = start + 2'(i);
            if (!p.found && r[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

    assign busy      = (state == OWN);
    assign transfer  = busy && bus.req[owner] && bus.out_ready;
    assign dropped   = busy && !bus.req[owner];
    assign last_beat = transfer && (beat_cnt == LAST_BEAT);

    // On release the scan restarts just past the owner; a dropping owner is masked out.
    always_comb begin
        arb_req   = bus.req;
        arb_start = ptr;
        if (busy) begin
            arb_start = owner + 2'd1;
            if (dropped) begin
                arb_req = bus.req & ~(4'b0001 << owner);
            end
        end
    end

    assign pick = rr_pick(arb_req, arb_start);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        beat_n  = beat_cnt;
        gnt_n   = gnt;

        unique case (state)
            IDLE: begin
                if (pick.found) begin
                    state_n = OWN;
                    owner_n = pick.idx;
                    gnt_n   = 4'b0001 << pick.idx;
                    beat_n  = 4'd0;
                end
            end
            OWN: begin
                if (transfer) begin
                    beat_n = beat_cnt + 4'd1;
                end
                if (last_beat || dropped) begin
                    ptr_n = owner + 2'd1;
                    if (pick.found) begin
                        owner_n = pick.idx;
                        gnt_n   = 4'b0001 << pick.idx;
                        beat_n  = 4'd0;
                    end else begin
                        state_n = IDLE;
                        owner_n = 2'd0;
                        gnt_n   = 4'd0;
                        beat_n  = 4'd0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            beat_cnt <= 4'd0;
            gnt      <= 4'd0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            beat_cnt <= beat_n;
            gnt      <= gnt_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.sel       = owner;
    assign bus.busy      = busy;
    assign bus.out_valid = busy && bus.req[owner];
    assign bus.out_data  = bus.data_in[int'(owner)*WIDTH +: WIDTH];

`ifdef MUXARB_PERF_CNT_EN
    logic [15:0] perf_cnt [4];

    // NOTE: this small array is reset explicitly because the counters must read zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                perf_cnt[k] <= 16'd0;
            end
        end else if (transfer && (perf_cnt[owner] != 16'hFFFF)) begin
            perf_cnt[owner] <= perf_cnt[owner] + 16'd1;
        end
    end

    assign cnt_out = perf_cnt[cnt_sel];
`endif

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
    a_beat_bound : assert property (@(posedge clk) disable iff (!reset_n) beat_cnt <= LAST_BEAT);

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: stimulus pushes expected beat owners, a negedge monitor pops and compares.
// Directed scenarios cover round-robin order, single requester, drop, backpressure, mid-burst reset and counters.
module tb_mux4_arbiter;

    localparam int WIDTH = 64;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic reset_n;

    mux4_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef MUXARB_PERF_CNT_EN
    logic [1:0]  cnt_sel;
    logic [15:0] cnt_out;
`endif

    mux4_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MUXARB_PERF_CNT_EN
        ,
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int beats     = 0;
    int exp_q [$];

    function automatic logic [63:0] pat(input int k);
        return 64'hC0DE_0000_0000_0000 | (64'(k) << 32) | (64'(k + 1) * 64'h1111);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int idx, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(idx);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_sel", 64'(bus.sel), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        bus.req = 4'b0000;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every accepted beat must match the next expected owner.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            int idx;
            beats++;
            if (exp_q.size() == 0) begin
                check("beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                idx = exp_q.pop_front();
                check("beat_sel", 64'(bus.sel), 64'(idx));
                check("beat_gnt", 64'(bus.gnt), 64'(1 << idx));
                check("beat_data", bus.out_data, pat(idx));
            end
        end
    end

    initial begin
        int b0;
        reset_n       = 1'b0;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        bus.data_in   = {pat(3), pat(2), pat(1), pat(0)};
`ifdef MUXARB_PERF_CNT_EN
        cnt_sel = 2'd0;
`endif

        // Round-robin from reset: 0x4, 1x4, 2x4, 3x4, then back to 0.
        do_reset();
        b0 = beats;
        push_beats(0, 4); push_beats(1, 4); push_beats(2, 4); push_beats(3, 4);
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        check("rr_latency_busy", 64'(bus.busy), 64'd0);
        tick();
        check("rr_first_gnt", 64'(bus.gnt), 64'b0001);
        repeat (16) tick();
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        check("rr_wrap_gnt", 64'(bus.gnt), 64'b0001);
        tick();
        check("rr_idle_busy", 64'(bus.busy), 64'd0);
        check("rr_beats", 64'(beats - b0), 64'd16);

        // Single requester: continuous grant, a beat every cycle across burst boundaries.
        do_reset();
        b0 = beats;
        push_beats(2, 8);
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        tick();
        check("single_gnt", 64'(bus.gnt), 64'b0100);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("single_gnt_hold", 64'(bus.gnt), 64'b0100);
        end
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        check("single_beats", 64'(beats - b0), 64'd8);

        // Drop: owner 1 leaves after 2 beats, requester 3 takes over with no bubble.
        do_reset();
        b0 = beats;
        push_beats(1, 2); push_beats(3, 4);
        bus.req       = 4'b1010;
        bus.out_ready = 1'b1;
        tick();
        check("drop_first_gnt", 64'(bus.gnt), 64'b0010);
        tick();
        tick();
        bus.req = 4'b1000;
        tick();
        check("drop_gnt", 64'(bus.gnt), 64'b1000);
        check("drop_sel", 64'(bus.sel), 64'd3);
        repeat (4) tick();
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        check("drop_beats", 64'(beats - b0), 64'd6);

        // Backpressure: 10 stalled cycles, then 4 beats of 0 and handover to 1.
        do_reset();
        b0 = beats;
        bus.req       = 4'b0011;
        bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_gnt", 64'(bus.gnt), 64'b0001);
            check("bp_data", bus.out_data, pat(0));
            check("bp_beat_cnt", 64'(dut.beat_cnt), 64'd0);
            tick();
        end
        push_beats(0, 4); push_beats(1, 4);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        check("bp_handover_gnt", 64'(bus.gnt), 64'b0010);
        repeat (4) tick();
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        check("bp_beats", 64'(beats - b0), 64'd8);

        // Reset mid-burst at beat_cnt 2; afterwards requester 1 wins from ptr 0.
        do_reset();
        b0 = beats;
        push_beats(0, 2);
        bus.req       = 4'b0001;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        bus.req = 4'b1010;
        tick();
        check("mid_rst_gnt", 64'(bus.gnt), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_gnt", 64'(bus.gnt), 64'b0010);
        check("post_rst_sel", 64'(bus.sel), 64'd1);
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        check("mid_rst_beats", 64'(beats - b0), 64'd2);

`ifdef MUXARB_PERF_CNT_EN
        // Counters: 70000 transfers by requester 2 saturate its counter only.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cnt_sel = 2'(k);
            #1;
            check("cnt_reset", 64'(cnt_out), 64'd0);
        end
        b0 = beats;
        push_beats(2, 70000);
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        tick();
        repeat (70000) tick();
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        check("cnt_beats", 64'(beats - b0), 64'd70000);
        for (int k = 0; k < 4; k++) begin
            cnt_sel = 2'(k);
            #1;
            check("cnt_value", 64'(cnt_out), (k == 2) ? 64'hFFFF : 64'd0);
        end
`endif

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
